// File: rtl/result_frame_tx.sv
// Result frame transmitter: captures N_POS two-channel result pairs from the pipeline,
// then streams them as HEADER, LEN, data bytes, CSUM over a valid/ready byte interface.
module result_frame_tx #(
  parameter int unsigned N_POS  = 36,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data_0,
  input  logic [7:0] in_data_1,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       overrun,
  output logic       frame_done
);

  localparam int unsigned    PtrW    = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam logic [7:0]     LenByte = 8'(2 * N_POS);
  localparam logic [PtrW-1:0] LastPos = PtrW'(N_POS - 1);

  typedef enum logic [2:0] {StIdle, StCapture, StHdr, StLen, StData, StCsum} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  // Byte currently on tx_data during DATA: entry rd_idx_q, channel rd_hi_q.
  logic [PtrW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_hi_q, rd_hi_d;
  logic [7:0]      checksum_q, checksum_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            frame_done_q, frame_done_d;

  logic [15:0]     buf_q [N_POS];

  logic            capture;
  logic            accept;
  logic            wr_en;
  logic [PtrW-1:0] rd_addr;
  logic [15:0]     rd_word;
  logic [7:0]      next_byte;
  logic [7:0]      sum_next;

  assign capture = ena & in_valid;
  assign accept  = tx_valid_q & tx_ready;

  // Byte following the one presented: upper half of the same entry, or lower half of the
  // next entry. At the final byte the address runs past the buffer; the value is unused.
  always_comb begin
    rd_addr   = rd_idx_q + PtrW'(rd_hi_q);
    rd_word   = buf_q[rd_addr];
    next_byte = rd_hi_q ? rd_word[7:0] : rd_word[15:8];
    sum_next  = checksum_q + tx_data_q;
  end

  // Next-state and output decode for the capture/transmit sequence.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_idx_d     = rd_idx_q;
    rd_hi_d      = rd_hi_q;
    checksum_d   = checksum_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          wr_en    = 1'b1;
          wr_ptr_d = PtrW'(1);
          busy_d   = 1'b1;
          if (N_POS == 1) begin
            state_d    = StHdr;
            tx_valid_d = 1'b1;
            tx_data_d  = HEADER;
          end else begin
            state_d = StCapture;
          end
        end
      end
      StCapture: begin
        if (capture) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LastPos) begin
            state_d    = StHdr;
            tx_valid_d = 1'b1;
            tx_data_d  = HEADER;
          end
        end
      end
      StHdr: begin
        if (accept) begin
          tx_data_d = LenByte;
          state_d   = StLen;
        end
      end
      StLen: begin
        if (accept) begin
          checksum_d = tx_data_q;
          tx_data_d  = buf_q[0][7:0];
          rd_idx_d   = '0;
          rd_hi_d    = 1'b0;
          state_d    = StData;
        end
      end
      StData: begin
        if (accept) begin
          checksum_d = sum_next;
          if (rd_idx_q == LastPos && rd_hi_q) begin
            tx_data_d = sum_next;
            state_d   = StCsum;
          end else begin
            tx_data_d = next_byte;
            rd_idx_d  = rd_addr;
            rd_hi_d   = ~rd_hi_q;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          tx_valid_d   = 1'b0;
          tx_data_d    = 8'h00;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          wr_ptr_d     = '0;
          rd_idx_d     = '0;
          rd_hi_d      = 1'b0;
          checksum_d   = 8'h00;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Captures arriving once the buffer is locked are lost; flag it until reset.
    if (capture && !(state_q inside {StIdle, StCapture})) overrun_d = 1'b1;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_idx_q     <= '0;
      rd_hi_q      <= 1'b0;
      checksum_q   <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_idx_q     <= rd_idx_d;
      rd_hi_q      <= rd_hi_d;
      checksum_q   <= checksum_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Result buffer, {ch1, ch0} per entry; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_ptr_q] <= {in_data_1, in_data_0};
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx: a frame-level queue model checked every cycle, plus literal checks.
module tb_result_frame_tx;

  localparam int N = 36;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_data_0;
  logic [7:0] in_data_1;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       overrun;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  // Every byte accepted by the host, in order.
  logic [7:0] rx[$];

  result_frame_tx #(.N_POS(N), .HEADER(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .overrun   (overrun),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host ready: always high, or the pattern 1,0,0,1 repeating.
  initial begin
    int rcnt;
    rcnt = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      tx_ready = (rdy_mode == 0) || (rcnt % 4 == 0) || (rcnt % 4 == 3);
    end
  end

  // Model: captured pairs accumulate until N, then the whole frame becomes a byte queue
  // that drains one entry per handshake.
  logic [15:0] m_caps[$];
  logic [7:0]  m_bytes[$];
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_done  = 1'b0;
  logic [7:0]  m_sum;

  always @(negedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
      m_done  = 1'b0;
      m_caps.delete();
      m_bytes.delete();
    end else begin
      chk("tx_valid", tx_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      chk("frame_done", frame_done, m_done);
      if (m_valid && m_bytes.size() > 0) chk("tx_data", tx_data, m_bytes[0]);
      if (tx_valid && tx_ready) rx.push_back(tx_data);

      m_done = 1'b0;
      if (m_valid) begin
        if (ena && in_valid) m_ovr = 1'b1;
        if (tx_ready) begin
          void'(m_bytes.pop_front());
          if (m_bytes.size() == 0) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b1;
          end
        end
      end else if (ena && in_valid) begin
        m_caps.push_back({in_data_1, in_data_0});
        m_busy = 1'b1;
        if (m_caps.size() == N) begin
          m_sum = 8'(2 * N);
          m_bytes.push_back(8'hA5);
          m_bytes.push_back(m_sum);
          foreach (m_caps[i]) begin
            m_bytes.push_back(m_caps[i][7:0]);
            m_bytes.push_back(m_caps[i][15:8]);
            m_sum = m_sum + m_caps[i][7:0] + m_caps[i][15:8];
          end
          m_bytes.push_back(m_sum);
          m_valid = 1'b1;
          m_caps.delete();
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic cap(input logic [7:0] a, input logic [7:0] b);
    ena       = 1'b1;
    in_valid  = 1'b1;
    in_data_0 = a;
    in_data_1 = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic gap(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      ena       = 1'b0;
      in_valid  = noise;
      in_data_0 = 8'($urandom);
      in_data_1 = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ena      = 1'b1;
  endtask

  task automatic wait_done(input int bound, output int vc, output logic ok);
    vc = 0;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_valid) vc++;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    int   vc;
    logic ok;
    reset = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data_0 = 8'h00; in_data_1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    gap(2, 1'b0);

    // Frame 1: ready held high, captures (k, 255-k).
    base = rx.size();
    for (int k = 0; k < N; k++) cap(8'(k), 8'(255 - k));
    wait_done(200, vc, ok);
    chk("f1_done_seen", ok, 1);
    chk("f1_valid_cycles", vc, 75);
    chk("f1_len", rx.size() - base, 75);
    chk("f1_b0", rx[base + 0], 8'hA5);
    chk("f1_b1", rx[base + 1], 8'h48);
    chk("f1_b2", rx[base + 2], 8'h00);
    chk("f1_b3", rx[base + 3], 8'hFF);
    chk("f1_b4", rx[base + 4], 8'h01);
    chk("f1_b5", rx[base + 5], 8'hFE);
    chk("f1_b72", rx[base + 72], 8'h23);
    chk("f1_b73", rx[base + 73], 8'hDC);
    chk("f1_csum", rx[base + 74], 8'h24);
    chk("f1_busy_low", busy, 0);
    gap(3, 1'b0);

    // Frame 2: same data under backpressure.
    rdy_mode = 1;
    base = rx.size();
    for (int k = 0; k < N; k++) cap(8'(k), 8'(255 - k));
    wait_done(400, vc, ok);
    chk("f2_done_seen", ok, 1);
    chk("f2_len", rx.size() - base, 75);
    chk("f2_b0", rx[base + 0], 8'hA5);
    chk("f2_b3", rx[base + 3], 8'hFF);
    chk("f2_csum", rx[base + 74], 8'h24);
    rdy_mode = 0;
    gap(2, 1'b0);

    // Frame 3: a capture attempted mid-DATA is dropped.
    base = rx.size();
    for (int k = 0; k < N; k++) cap(8'(k), 8'(255 - k));
    gap(6, 1'b0);
    cap(8'd77, 8'd77);
    wait_done(200, vc, ok);
    chk("f3_done_seen", ok, 1);
    chk("f3_overrun", overrun, 1);
    chk("f3_len", rx.size() - base, 75);
    chk("f3_csum", rx[base + 74], 8'h24);

    // Frame 4: next frame still correct; overrun stays sticky.
    for (int k = 0; k < N; k++) cap(8'(3 * k), 8'(k) ^ 8'h5A);
    wait_done(200, vc, ok);
    chk("f4_done_seen", ok, 1);
    chk("f4_overrun_sticky", overrun, 1);

    // Frame 5: async reset during DATA.
    for (int k = 0; k < N; k++) cap(8'(k + 100), 8'(k));
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Frame 6: fresh frame after reset.
    base = rx.size();
    for (int k = 0; k < N; k++) cap(8'(255 - k), 8'(7 * k));
    wait_done(200, vc, ok);
    chk("f6_done_seen", ok, 1);
    chk("f6_b0", rx[base + 0], 8'hA5);
    chk("f6_b1", rx[base + 1], 8'h48);
    chk("f6_b2", rx[base + 2], 8'hFF);
    chk("f6_len", rx.size() - base, 75);

    // Frame 7: gaps of 1-5 cycles, some with in_valid high but ena low.
    base = rx.size();
    for (int k = 0; k < N; k++) begin
      cap(8'(5 * k), ~8'(k));
      if (k < N - 1) gap(1 + k % 5, k[0]);
    end
    wait_done(200, vc, ok);
    chk("f7_done_seen", ok, 1);
    chk("f7_valid_cycles", vc, 75);
    chk("f7_len", rx.size() - base, 75);
    chk("f7_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
- Output-side counterpart to the serial pixel loader: the loader receives a frame byte-by-byte; this block captures the per-position two-channel results of the network pipeline and transmits them as one framed byte stream.
- The stream goes out over the 8-bit output pins under a valid/ready handshake. The host drives ready through a bidirectional input bit.
- Sits between the last pipeline stage's (data_0, data_1, valid) outputs and the top-level output registers.

Parameters:
- N_POS, 36, number of result positions per frame; constraint 1 <= N_POS and 2*N_POS <= 255.
- HEADER, 8'hA5, start-of-frame marker byte.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  capture enable; when low, in_valid is ignored.
- in_valid  input  1  result pair present on in_data_0/in_data_1 this cycle.
- in_data_0  input  8  channel-0 result (unsigned).
- in_data_1  input  8  channel-1 result (unsigned).
- tx_ready  input  1  host accepts tx_data this cycle.
- tx_data  output  8  transmitted byte (registered).
- tx_valid  output  1  tx_data valid (registered).
- busy  output  1  high from first capture until frame_done.
- overrun  output  1  sticky: a result was dropped while transmitting.
- frame_done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (async, immediate): tx_data=0, tx_valid=0, busy=0, overrun=0, frame_done=0; state IDLE, wr_ptr=0, rd_ptr=0, checksum=0. Buffer contents are don't-care.
- Buffer: N_POS entries x 16 bits, {ch1,ch0}. Written only in IDLE/CAPTURE.
- A capture occurs when ena && in_valid.
- States and transitions:
  - IDLE: on capture, write entry 0, wr_ptr<=1, busy<=1, go to CAPTURE. If N_POS==1, go directly to HDR.
  - CAPTURE: each capture writes entry wr_ptr and increments wr_ptr. The capture into entry N_POS-1 moves the block to HDR on the same edge. Capture gaps of any length are allowed.
  - HDR: tx_valid=1, tx_data=HEADER, presented on the first cycle after the last capture. On tx_valid&&tx_ready, go to LEN.
  - LEN: tx_data=2*N_POS (8'h48 at default). checksum<=tx_data on accept; go to DATA.
  - DATA: send 2*N_POS bytes in order entry0.ch0, entry0.ch1, entry1.ch0, … On each accept, checksum<=checksum+byte (mod 256). After the last byte is accepted, go to CSUM.
  - CSUM: tx_data=checksum, i.e. the 8-bit sum of the LEN byte and all data bytes; HEADER is excluded. On accept: frame_done pulses the next cycle, busy<=0, tx_valid<=0, pointers and checksum cleared, go to IDLE.
- Handshake:
  - A transfer happens on an edge where tx_valid&&tx_ready.
  - While tx_valid&&!tx_ready, tx_data is held stable.
  - tx_ready is ignored while tx_valid=0.
  - With tx_ready held high the block sends one byte per cycle, so a frame takes exactly 2*N_POS+3 cycles from HDR entry to CSUM accept.
  - tx_valid never deasserts mid-frame.
- Overrun:
  - A capture attempted in HDR/LEN/DATA/CSUM is dropped, buffer untouched, and overrun<=1.
  - overrun is cleared only by reset.
  - in_valid with ena=0 is ignored and never sets overrun.
- Simultaneous events:
  - A capture in the cycle of the CSUM accept is dropped and counts as overrun, because the state is still CSUM.
  - A capture in the cycle frame_done is high starts a new frame normally, because the state is IDLE.
- Reset mid-frame: the in-progress frame is abandoned with no partial checksum. The next capture after release starts at entry 0.

Test Plan:
- Reset check: assert reset mid-simulation without a clock edge -> tx_valid, busy, overrun, frame_done all 0 immediately.
- Full frame, tx_ready=1: captures (k, 255-k) for k=0..35 -> byte stream A5, 48, 00, FF, 01, FE, …, 23, DC, 24; 75 consecutive valid cycles; frame_done pulses once; busy falls.
- Backpressure: same frame with tx_ready = 1,0,0,1 repeating -> identical byte sequence, no duplicates or losses, tx_data stable during every stall.
- Overrun: in_valid pulse (data 77,77) during DATA -> overrun=1 and stays set, frame bytes and checksum unchanged. Next frame after frame_done is captured and sent correctly.
- Async reset during DATA (after 10 data bytes) -> tx_valid=0 at once. New 36-capture frame -> stream starts with A5, 48 and holds the new data.
- Capture gaps and ena gating: in_valid with ena=0 interleaved, plus idle gaps of 1–5 cycles -> only ena&&in_valid pairs stored; HDR appears exactly one cycle after the 36th real capture; overrun stays 0.
